// File: rtl/ram_timing_model.sv
// Single-port 32-bit word memory that models a fixed access latency.
// A request held stable for LAT cycles gets one ACCESS cycle. Read data
// is loaded into ramload on the edge before ACCESS. Write data is committed
// on the edge that ends the ACCESS cycle.
module ram_timing_model #(
  parameter int LAT   = 4,
  parameter int DEPTH = 1024
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  input  logic        ramREN,
  input  logic        ramWEN,
  output logic [31:0] ramload,
  output logic [1:0]  ramstate
);
  // state   | meaning
  // IDLE    | no request is being timed
  // COUNT   | request latched, waiting for r_cnt to run down
  // HIT     | latency elapsed, ACCESS while the latched request is held
  typedef enum logic [1:0] {IDLE, COUNT, HIT} state_t;

  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  localparam logic [1:0] ST_FREE   = 2'b00;
  localparam logic [1:0] ST_BUSY   = 2'b01;
  localparam logic [1:0] ST_ACCESS = 2'b10;
  localparam logic [1:0] ST_ERROR  = 2'b11;

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_cnt, w_cnt_nxt;
  logic [AW-1:0] r_lat_addr, w_lat_addr_nxt;
  logic          r_lat_wr, w_lat_wr_nxt;
  logic [31:0]   r_ramload;
  logic [31:0]   r_mem [DEPTH];

  logic [29:0]   w_widx;
  logic          w_req;
  logic          w_bad;
  logic          w_match;
  logic          w_load;
  logic [AW-1:0] w_load_addr;
  logic          w_commit;
  logic          w_unused_addr_lsb;

  assign w_widx            = ramaddr[31:2];
  assign w_unused_addr_lsb = ^ramaddr[1:0];
  assign w_req             = ramREN ^ ramWEN;
  assign w_bad             = (ramREN & ramWEN) |
                             (w_req & ({2'b00, w_widx} >= 32'(DEPTH)));
  // Only meaningful when w_bad is low; w_bad takes priority everywhere.
  assign w_match           = w_req & (w_widx == 30'(r_lat_addr)) &
                             (ramWEN == r_lat_wr);

  assign ramload = r_ramload;

  // Status decode: error first, ACCESS only while the latched request is held in HIT.
  always_comb begin
    ramstate = ST_FREE;
    if (w_bad)
      ramstate = ST_ERROR;
    else if ((r_state == HIT) && w_match)
      ramstate = ST_ACCESS;
    else if (w_req)
      ramstate = ST_BUSY;
  end

  // Next-state, counter and latch updates, plus read-load and write-commit strobes.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_lat_addr_nxt = r_lat_addr;
    w_lat_wr_nxt   = r_lat_wr;
    w_load         = 1'b0;
    w_load_addr    = r_lat_addr;
    w_commit       = 1'b0;
    if (w_bad || !w_req) begin
      w_state_nxt = IDLE;
    end else if ((r_state == IDLE) || !w_match) begin
      // New request, or the request changed: restart the full latency.
      w_lat_addr_nxt = w_widx[AW-1:0];
      w_lat_wr_nxt   = ramWEN;
      if (LAT == 1) begin
        w_state_nxt = HIT;
        w_load      = !ramWEN;
        w_load_addr = w_widx[AW-1:0];
      end else begin
        w_state_nxt = COUNT;
        w_cnt_nxt   = CNT_INIT;
      end
    end else if (r_state == COUNT) begin
      if (r_cnt > 4'd1) begin
        w_cnt_nxt = r_cnt - 4'd1;
      end else begin
        w_state_nxt = HIT;
        w_load      = !r_lat_wr;
      end
    end else if (r_state == HIT) begin
      // ACCESS cycle ends; a still-held request must wait the full latency again.
      w_commit    = r_lat_wr;
      w_state_nxt = IDLE;
    end else begin
      w_state_nxt = IDLE;
    end
  end

  // Control registers and read-data register, cleared by reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_lat_addr <= '0;
      r_lat_wr   <= 1'b0;
      r_ramload  <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_lat_addr <= w_lat_addr_nxt;
      r_lat_wr   <= w_lat_wr_nxt;
      if (w_load)
        r_ramload <= r_mem[w_load_addr];
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge CLK) begin
    if (w_commit)
      r_mem[r_lat_addr] <= ramstore;
  end

endmodule

// File: doc/ram_timing_model.md
Name: ram_timing_model

Overview:
- Cycle-accurate, single-port word memory with configurable access latency. It sits directly downstream of the memory controller and is the only consumer of its RAM request bus.
- Returns read data and a per-cycle status. The controller uses the ACCESS status to release its instruction-wait and data-wait outputs.
- Used in simulation and in the synthesized FPGA build, so a real storage array is required.

Parameters:
- LAT, 4: cycles from first request cycle to ACCESS cycle; legal range 1..15.
- DEPTH, 1024: number of 32-bit words in the array; power of two.

Ports:
- CLK, input, 1: single clock; all state updates on its rising edge.
- nRST, input, 1: reset, asynchronous, active-low.
- ramaddr, input, 32: byte address; bits [1:0] ignored.
- ramstore, input, 32: write data.
- ramREN, input, 1: read request.
- ramWEN, input, 1: write request.
- ramload, output, 32: read data, registered.
- ramstate, output, 2: status. FREE=2'b00, BUSY=2'b01, ACCESS=2'b10, ERROR=2'b11.

Behaviour:
- Definitions:
  - widx = ramaddr[31:2].
  - req = ramREN XOR ramWEN.
  - bad = (ramREN AND ramWEN) OR (req AND widx >= DEPTH).
- Internal state:
  - FSM {IDLE, COUNT, HIT}.
  - Latched request: lat_addr, lat_wr.
  - Down-counter cnt, 4 bits.
- Reset (async, nRST=0):
  - FSM=IDLE, cnt=0, lat_addr=0, lat_wr=0, ramload=0.
  - ramstate therefore reads FREE.
  - Array contents are not cleared. Reset asserted mid-access aborts the access; no write is committed.
- match = req AND widx==lat_addr AND ramWEN==lat_wr.
- ramstate is combinational from FSM state and inputs, evaluated in priority order:
  - bad: ERROR.
  - IDLE: BUSY if req, else FREE.
  - COUNT: BUSY if req, else FREE.
  - HIT: ACCESS if match; BUSY if req and not match; FREE if no req.
- Transitions, one decision per rising edge:
  - Any state with bad: go to IDLE. No commit, ramload holds.
  - Any state with no req: go to IDLE.
  - IDLE with req:
    - Latch lat_addr=widx and lat_wr=ramWEN.
    - If LAT==1: go to HIT, and for a read load ramload=mem[widx].
    - Else: go to COUNT with cnt=LAT-1.
  - COUNT with req and not match: restart. Relatch the request, cnt=LAT-1, stay in COUNT. For LAT==1 apply the IDLE rule instead.
  - COUNT with match and cnt>1: cnt=cnt-1.
  - COUNT with match and cnt==1: go to HIT; for a read load ramload=mem[lat_addr].
  - HIT with match:
    - Write: mem[lat_addr]=ramstore, sampled this edge.
    - Go to IDLE. A request still held next cycle is a new request with full latency; there is no repeat ACCESS without re-waiting.
  - HIT with req and not match: restart as in COUNT.
- Resulting latency: a request first presented in cycle N and held stable reads ACCESS in cycle N+LAT, for exactly one cycle.
  - Read data is valid on ramload during the ACCESS cycle.
  - ramload holds that value until the next read load.
  - Write data becomes visible to a read whose ACCESS is at N+LAT+1 or later.
- Changes to ramstore during COUNT do not restart; only the value at the HIT edge is written.
- Switching from read to write at the same address restarts the access, because lat_wr differs.
- Single port, so there are no read/write collision hazards. A read loaded into ramload never observes a write committed on the same edge, because the FSM forbids it.

Test Plan:
- Write-then-read (LAT=4):
  - Write 0xDEADBEEF at 0x40 from cycle 0: BUSY at cycles 0-3, ACCESS at 4.
  - Read 0x40 from cycle 5: ACCESS at 9 with ramload=0xDEADBEEF, held after.
- Address change mid-wait:
  - Read 0x80 in cycles 0-1, then switch to 0x84 at cycle 2: BUSY continues, ACCESS first at cycle 6.
  - ramload equals mem[0x84]; no ACCESS is reported for 0x80.
- Protocol errors:
  - ramREN=ramWEN=1 at 0x10: ramstate=ERROR every cycle; mem[0x10] unchanged on a later read.
  - Read of 0x1000 with DEPTH=1024: ERROR.
- Held request and reset:
  - Read 0x20 held for 12 cycles: ACCESS at cycles 4 and 9 only; BUSY otherwise.
  - Drive nRST=0 in cycle 2 of a write to 0x24, release: ramstate=FREE, ramload=0, mem[0x24] keeps its old value.
- LAT=1 corner:
  - Back-to-back reads 0x00 and 0x04, each held one ACCESS: ACCESS at cycles 1 and 3, correct data both times.
  - Write then read of the same word: read returns the new data.
